// File: rtl/alu_seq_unit.sv
// alu_seq_unit
//   Multi-cycle ALU execution unit. Decodes ALUOp/funct3/funct7_5/op_5 into
//   a 4-bit ALU control code, then executes on XLEN-bit operands. Logic and
//   arithmetic ops finish in one cycle; shifts step one bit per cycle.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (in_ready high only in IDLE)
//   alu_op, funct3,
//   funct7_5, op_5      : decoder fields selecting the operation
//   src_a, src_b        : operands (shift amount = src_b[SHW-1:0])
//   out_valid/out_ready : result handshake (out_valid held until accepted)
//   result, zero        : registered result and (result == 0)
//   alu_control         : registered control code of current/last op
//   illegal             : registered flag, op was undecodable
module alu_seq_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            op_5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_control,
    output logic            illegal
);

    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b0001,
        ALU_AND     = 4'b0010,
        ALU_OR      = 4'b0011,
        ALU_XOR     = 4'b0100,
        ALU_SLT     = 4'b0101,
        ALU_SLTU    = 4'b0110,
        ALU_SLL     = 4'b1000,
        ALU_SRL     = 4'b1001,
        ALU_SRA     = 4'b1010,
        ALU_ILLEGAL = 4'b1111
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    alu_ctrl_t         r_ctrl;
    logic [XLEN-1:0]   r_result;
    logic [XLEN-1:0]   r_acc;
    logic [SHW-1:0]    r_cnt;
    logic              r_zero;
    logic              r_illegal;
    logic              r_out_valid;

    alu_ctrl_t         w_ctrl;
    logic              w_is_shift;
    logic [SHW-1:0]    w_amt;
    logic [XLEN-1:0]   w_alu_res;
    logic [XLEN-1:0]   w_acc_next;

    // Field decode into the extended control code
    always_comb begin
        w_ctrl = ALU_ILLEGAL;
        unique case (alu_op)
            2'b00: w_ctrl = ALU_ADD;
            2'b01: w_ctrl = ALU_SUB;
            2'b11: w_ctrl = ALU_ILLEGAL;
            2'b10: begin
                unique case (funct3)
                    3'b000: w_ctrl = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: w_ctrl = ALU_SLL;
                    3'b010: w_ctrl = ALU_SLT;
                    3'b011: w_ctrl = ALU_SLTU;
                    3'b100: w_ctrl = ALU_XOR;
                    3'b101: w_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: w_ctrl = ALU_OR;
                    3'b111: w_ctrl = ALU_AND;
                    default: w_ctrl = ALU_ILLEGAL;
                endcase
            end
            default: w_ctrl = ALU_ILLEGAL;
        endcase
    end

    assign w_is_shift = (w_ctrl == ALU_SLL) || (w_ctrl == ALU_SRL) || (w_ctrl == ALU_SRA);
    assign w_amt      = src_b[SHW-1:0];

    // Single-cycle datapath; a shift only lands here when its amount is 0,
    // in which case the result is the unshifted operand.
    always_comb begin
        w_alu_res = '0;
        case (w_ctrl)
            ALU_ADD:  w_alu_res = src_a + src_b;
            ALU_SUB:  w_alu_res = src_a - src_b;
            ALU_AND:  w_alu_res = src_a & src_b;
            ALU_OR:   w_alu_res = src_a | src_b;
            ALU_XOR:  w_alu_res = src_a ^ src_b;
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  w_alu_res = src_a;
            default:  w_alu_res = '0;
        endcase
    end

    // One-bit shift step of the accumulator, direction from the latched code
    always_comb begin
        w_acc_next = r_acc;
        case (r_ctrl)
            ALU_SLL: w_acc_next = {r_acc[XLEN-2:0], 1'b0};
            ALU_SRL: w_acc_next = {1'b0, r_acc[XLEN-1:1]};
            ALU_SRA: w_acc_next = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
            default: w_acc_next = r_acc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ctrl      <= ALU_ADD;
            r_result    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ctrl    <= w_ctrl;
                        r_illegal <= (w_ctrl == ALU_ILLEGAL);
                        if (w_is_shift && (w_amt != '0)) begin
                            r_acc   <= src_a;
                            r_cnt   <= w_amt;
                            r_state <= S_SHIFT;
                        end else begin
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - SHW'(1);
                    // Last step: capture the shifted value directly so DONE
                    // follows exactly 'amount' SHIFT cycles.
                    if (r_cnt == SHW'(1)) begin
                        r_result    <= w_acc_next;
                        r_zero      <= (w_acc_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign zero        = r_zero;
    assign alu_control = r_ctrl;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit
//   Self-checking bench for alu_seq_unit: directed vector table, directed
//   multi-cycle sequences (long shift with back-pressure, reset mid-shift)
//   and randomized ops checked against a behavioural reference model.
module tb_alu_seq_unit;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            op_5;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [3:0]      alu_control;
    logic            illegal;

    int total = 0;
    int bad   = 0;

    alu_seq_unit #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .op_5(op_5),
        .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .alu_control(alu_control), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic        op5;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] res;
        int          lat;
    } ref_t;

    // Reference model: mnemonic selection, then plain arithmetic on the whole
    // operand; a shift of n takes 1+n cycles (n=0 behaves like a 1-cycle op).
    function automatic ref_t model(input logic [1:0] op, input logic [2:0] f3,
                                   input logic f75, input logic op5,
                                   input logic [31:0] a, input logic [31:0] b);
        ref_t r;
        int   n;
        n     = int'(b % 32);
        r.lat = 1;
        r.res = 0;
        if (op == 2'b00)      begin r.ctrl = 4'd0;  r.res = a + b; end
        else if (op == 2'b01) begin r.ctrl = 4'd1;  r.res = a - b; end
        else if (op == 2'b11) begin r.ctrl = 4'hF;  r.res = 0;     end
        else begin
            case (f3)
                3'd0: if (op5 && f75) begin r.ctrl = 4'd1; r.res = a - b; end
                      else            begin r.ctrl = 4'd0; r.res = a + b; end
                3'd1: begin r.ctrl = 4'd8; r.res = a << n; r.lat = 1 + n; end
                3'd2: begin r.ctrl = 4'd5; r.res = ($signed(a) < $signed(b)) ? 1 : 0; end
                3'd3: begin r.ctrl = 4'd6; r.res = (a < b) ? 1 : 0; end
                3'd4: begin r.ctrl = 4'd4; r.res = a ^ b; end
                3'd5: if (f75) begin r.ctrl = 4'hA; r.res = $signed(a) >>> n; r.lat = 1 + n; end
                      else     begin r.ctrl = 4'd9; r.res = a >> n;           r.lat = 1 + n; end
                3'd6: begin r.ctrl = 4'd3; r.res = a | b; end
                default: begin r.ctrl = 4'd2; r.res = a & b; end
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic recover();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one op and follow it to the result handshake. Checks latency,
    // result fields, busy in_ready, stability while held, and release.
    task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                          input logic op5, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ectrl, input logic [31:0] eres, input int elat,
                          input int hold, input bit junk, input bit rdy_noise, input string tag);
        int cyc;
        bit seen;
        bit busy_ok;
        bit stable_ok;
        @(negedge clk);
        check({tag, " in_ready idle"}, {31'b0, in_ready}, 32'd1);
        alu_op = op; funct3 = f3; funct7_5 = f75; op_5 = op5;
        src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // scramble inputs: the unit must work from latched values
        alu_op = 2'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
        op_5 = 1'($urandom); src_a = $urandom; src_b = $urandom;
        cyc = 0; seen = 0; busy_ok = 1;
        while (!seen && cyc <= XLEN + 4) begin
            @(negedge clk);
            cyc++;
            if (in_ready) busy_ok = 0;
            if (out_valid) seen = 1;
            else begin
                in_valid  = junk;
                out_ready = rdy_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check({tag, " latency"}, seen ? cyc : -1, elat);
        check({tag, " busy in_ready"}, {31'b0, busy_ok}, 32'd1);
        if (!seen) begin
            recover();
            return;
        end
        check({tag, " result"},  result, eres);
        check({tag, " zero"},    {31'b0, zero}, {31'b0, (eres == 0)});
        check({tag, " ctrl"},    {28'b0, alu_control}, {28'b0, ectrl});
        check({tag, " illegal"}, {31'b0, illegal}, {31'b0, (ectrl == 4'hF)});
        stable_ok = 1;
        for (int k = 0; k < hold; k++) begin
            in_valid = junk;
            @(negedge clk);
            if (!out_valid || in_ready || result !== eres || alu_control !== ectrl) stable_ok = 0;
        end
        if (hold > 0) check({tag, " held stable"}, {31'b0, stable_ok}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " released"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    vec_t vecs[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ref_t m;
        logic [1:0]  r_op;
        logic [2:0]  r_f3;
        logic        r_f75, r_op5;
        logic [31:0] r_a, r_b;
        bit          nv_ok;

        vecs[0]  = '{2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd7, 4'h1, 32'hFFFFFFFE, 1};
        vecs[1]  = '{2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 4'h0, 32'd12, 1};
        vecs[2]  = '{2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 4'h5, 32'd1, 1};
        vecs[3]  = '{2'b10, 3'b011, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 4'h6, 32'd0, 1};
        vecs[4]  = '{2'b01, 3'b110, 1'b0, 1'b0, 32'd9, 32'd9, 4'h1, 32'd0, 1};
        vecs[5]  = '{2'b10, 3'b101, 1'b1, 1'b1, 32'h80000000, 32'h24, 4'hA, 32'hF8000000, 5};
        vecs[6]  = '{2'b10, 3'b101, 1'b0, 1'b1, 32'h80000000, 32'h24, 4'h9, 32'h08000000, 5};
        vecs[7]  = '{2'b11, 3'b001, 1'b0, 1'b1, 32'h1234, 32'h5, 4'hF, 32'd0, 1};
        vecs[8]  = '{2'b00, 3'b101, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, 4'h0, 32'd0, 1};
        vecs[9]  = '{2'b10, 3'b001, 1'b0, 1'b1, 32'd3, 32'h20, 4'h8, 32'd3, 1};
        vecs[10] = '{2'b10, 3'b100, 1'b0, 1'b1, 32'hF0F0, 32'h0FF0, 4'h4, 32'hFF00, 1};
        vecs[11] = '{2'b10, 3'b110, 1'b0, 1'b1, 32'hF0, 32'h0F, 4'h3, 32'hFF, 1};
        vecs[12] = '{2'b10, 3'b111, 1'b0, 1'b1, 32'hF0, 32'h3C, 4'h2, 32'h30, 1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; op_5 = 1'b0;
        src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        check("reset out_valid",   {31'b0, out_valid}, 32'd0);
        check("reset result",      result, 32'd0);
        check("reset zero",        {31'b0, zero}, 32'd0);
        check("reset ctrl",        {28'b0, alu_control}, 32'd0);
        check("reset illegal",     {31'b0, illegal}, 32'd0);
        check("reset in_ready",    {31'b0, in_ready}, 32'd1);
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].f3, vecs[i].f75, vecs[i].op5, vecs[i].a, vecs[i].b,
                   vecs[i].ctrl, vecs[i].res, vecs[i].lat, 1, 1'b1, 1'b0, $sformatf("vec%0d", i));

        // longest shift, result held through 3 cycles of back-pressure
        run_op(2'b10, 3'b001, 1'b0, 1'b1, 32'd1, 32'd31, 4'h8, 32'h80000000, 32,
               3, 1'b1, 1'b0, "sll31");

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom); r_f3 = 3'($urandom); r_f75 = 1'($urandom); r_op5 = 1'($urandom);
            r_a = $urandom; r_b = $urandom;
            if (i % 4 == 0) r_b = r_a;
            m = model(r_op, r_f3, r_f75, r_op5, r_a, r_b);
            run_op(r_op, r_f3, r_f75, r_op5, r_a, r_b, m.ctrl, m.res, m.lat,
                   $urandom_range(0, 2), 1'($urandom), 1'b1, $sformatf("rnd%0d", i));
        end

        // reset in the middle of a 20-bit shift
        run_op(2'b10, 3'b100, 1'b0, 1'b1, 32'h00FF, 32'hF000, 4'h4, 32'hF0FF, 1,
               0, 1'b0, 1'b0, "pre_rst");
        @(negedge clk);
        alu_op = 2'b10; funct3 = 3'b101; funct7_5 = 1'b0; op_5 = 1'b1;
        src_a = 32'hFFFFFFFF; src_b = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("midshift in_ready", {31'b0, in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst in_ready",  {31'b0, in_ready}, 32'd1);
        check("async rst result",    result, 32'd0);
        check("async rst ctrl",      {28'b0, alu_control}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nv_ok = 1;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || !in_ready) nv_ok = 0;
        end
        check("no result after rst", {31'b0, nv_ok}, 32'd1);

        run_op(2'b00, 3'b000, 1'b0, 1'b0, 32'd40, 32'd2, 4'h0, 32'd42, 1,
               0, 1'b0, 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, multi-cycle ALU execution unit: decodes the main decoder's ALUOp/funct3/funct7_5/op_5 fields into an extended 4-bit ALU control code and executes the operation on XLEN-bit operands. Single-cycle ops (add, sub, and, or, xor, slt, sltu) complete in one cycle; shifts (sll, srl, sra) use an iterative one-bit-per-cycle shifter. Sits between the control decoder and the register-file writeback of the multi-cycle core, with valid/ready handshakes on both sides.

## Interface
- XLEN, 32, operand/result width (power of two, ≥8)
- SHW, 5, shift-amount width; must equal log2(XLEN)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- alu_op  in  2  ALUOp from main decoder
- funct3  in  3  instruction funct3
- funct7_5  in  1  instruction bit 30
- op_5  in  1  opcode bit 5 (1 = R-type)
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B (shift amount in [SHW-1:0])
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  registered (result == 0)
- alu_control  out  4  registered decoded control code of the current/last op
- illegal  out  1  registered; op was undecodable

## Operation
- Decode: alu_op 00 → ADD; 01 → SUB; 11 → illegal; 10 → by funct3: 000 SUB if op_5&funct7_5 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct7_5 else SRL; 110 OR; 111 AND.
- Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 1000, SRL 1001, SRA 1010, illegal 1111.
- Arithmetic: ADD/SUB modulo 2^XLEN, no overflow flag. SLT signed, SLTU unsigned; result is 1 or 0, zero-extended.
- Shifts: amount = src_b[SHW-1:0]; upper bits ignored. SRA replicates src_a[XLEN-1] each step.
- Illegal: result = 0, zero = 1, illegal = 1, latency as single-cycle op.
- FSM: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid: latch alu_control, operands. Non-shift, illegal, or shift with amount 0 → compute, go DONE. Shift with amount ≠ 0 → acc=src_a, cnt=amount, go SHIFT.
  - SHIFT: each cycle acc shifts one bit, cnt decrements; when cnt reaches 0, result=acc, go DONE.
  - DONE: out_valid=1; result/zero/illegal/alu_control stable. On out_ready → IDLE.
- Inputs in SHIFT/DONE ignored; in_valid need not be held after acceptance.

## Timing
- Reset (async, immediate): state IDLE, out_valid 0, result 0, zero 0, illegal 0, alu_control 0000, cnt 0; in_ready 1 while in IDLE including during reset.
- Acceptance cycle = cycle 0 (in_valid & in_ready high at edge). out_valid first high in cycle 1 for non-shift/illegal/amount-0; cycle 1+amount for shifts.
- Max throughput: one op per 2 cycles (accept, DONE with out_ready=1, accept next in following IDLE cycle).
- out_valid drops in the cycle after the out_ready handshake edge; in_ready rises in that same cycle.
- out_ready high while not in DONE: no effect.
- Reset mid-SHIFT or mid-DONE: op discarded, outputs go to reset values asynchronously, no result produced.
- amount = XLEN-1 (31): out_valid at cycle 32; no wrap of cnt.

## Test plan
- Reset with in_valid=0 → out_valid 0, result 0, zero 0, alu_control 0000, in_ready 1.
- alu_op=10, funct3=000, op_5=1, funct7_5=1, A=5, B=7 → cycle 1: alu_control 0001, result 0xFFFFFFFE, zero 0; same with op_5=0 → ADD, result 12.
- alu_op=10, funct3=010 vs 011, A=0xFFFFFFFF, B=1 → SLT result 1, SLTU result 0; alu_op=01, A=B=9 → result 0, zero 1.
- alu_op=10, funct3=101, funct7_5=1, A=0x80000000, B=0x00000024 (amount 4) → out_valid at cycle 5, result 0xF8000000, alu_control 1010; funct7_5=0 → 0x08000000.
- SLL A=1, B=31 with out_ready=0 for 3 extra cycles → out_valid at cycle 32, result 0x80000000 held stable; in_valid pulses during busy ignored; in_ready rises after out_ready handshake.
- alu_op=11 → illegal 1, result 0, alu_control 1111 at cycle 1; reset asserted mid-SHIFT of a 20-bit shift → out_valid stays 0, in_ready 1 immediately.
